imem_arbiter: RTL

- Owns the single-port instruction memory (IMEM) and shares it between the boot loader (write requester) and the CPU fetch stage (read requester).
- Holds the CPU in reset while the program image is loaded.
- Once loading is done, arbitrates loader writes against CPU fetches each cycle and bounds fetch starvation.
- Sits between cpu fetch logic, the loader (UART/testbench preload) and the IMEM macro.

---
 rtl/imem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Owns the single-port instruction memory and shares it between the boot
//   loader (writes) and the CPU fetch stage (reads). The CPU is held in reset
//   while the image is loaded (BOOT). After the loader signals completion
//   (RUN), loader writes and CPU fetches are arbitrated every cycle. A streak
//   counter bounds how long a waiting fetch can be starved by the loader.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   ldr_req/addr/data -> ldr_ack  loader write request, same-cycle acknowledge
//   ldr_done                      one-cycle pulse: image load complete
//   cpu_rst_n                     active-low reset to the CPU core
//   fetch_req/pc -> fetch_gnt     CPU fetch request (byte PC), same-cycle grant
//   fetch_rvalid/rdata/err        fetch response, one cycle after the grant
//   cpu_stall                     fetch_req & ~fetch_gnt
//   mem_en/we/addr/wdata/rdata    IMEM macro interface (synchronous read)
module imem_arbiter #(
    parameter int                ADDR_W         = 9,
    parameter int                DATA_W         = 32,
    parameter int                MAX_LDR_STREAK = 4,
    parameter logic [DATA_W-1:0] NOP_INSN       = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_data,
    output logic              ldr_ack,
    input  logic              ldr_done,
    output logic              cpu_rst_n,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_err,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_LDR_STREAK + 1);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                cpu_rst_n_q;
    logic                rvalid_q;
    logic                err_q;
    logic [DATA_W-1:0]   rdata_hold_q;

    logic                ldr_gnt;
    logic                fch_gnt;
    logic                streak_full;
    logic                fetch_fault;
    logic [ADDR_W-1:0]   fetch_word;

    // Fetch decode: word index plus fault on misalignment or a PC beyond IMEM.
    assign fetch_word  = fetch_pc[ADDR_W+1:2];
    assign fetch_fault = (fetch_pc[1:0] != 2'b00) || (fetch_pc[31:ADDR_W+2] != '0);
    assign streak_full = (streak_q == STREAK_W'(MAX_LDR_STREAK));

    // Arbitration and next state. At most one grant per cycle, so a write and
    // a read never share a cycle and write-then-read needs no bypass.
    always_comb begin
        state_d  = state_q;
        streak_d = '0;
        ldr_gnt  = 1'b0;
        fch_gnt  = 1'b0;
        case (state_q)
            S_BOOT: begin
                // Loader only; a write coinciding with ldr_done still completes.
                ldr_gnt = ldr_req;
                if (ldr_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                ldr_gnt = ldr_req && !(fetch_req && streak_full);
                fch_gnt = fetch_req && !ldr_gnt;
                // Count loader wins against a waiting fetch. A loader win under
                // contention implies the counter is below the limit, so the
                // increment saturates naturally; any other case clears it.
                if (fetch_req && ldr_gnt) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // IMEM drive: faulting fetches are granted but leave the memory idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ldr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_data;
        end else if (fch_gnt && !fetch_fault) begin
            mem_en   = 1'b1;
            mem_addr = fetch_word;
        end
    end

    // Response data: memory word arrives the cycle after the grant; a fault
    // returns a NOP; otherwise the last delivered word is held.
    always_comb begin
        fetch_rdata = rdata_hold_q;
        if (rvalid_q) begin
            fetch_rdata = err_q ? NOP_INSN : mem_rdata;
        end
    end

    assign ldr_ack      = ldr_gnt;
    assign fetch_gnt    = fch_gnt;
    assign cpu_stall    = fetch_req && !fch_gnt;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign fetch_rvalid = rvalid_q;
    assign fetch_err    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            streak_q     <= '0;
            cpu_rst_n_q  <= 1'b0;
            rvalid_q     <= 1'b0;
            err_q        <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            // Registered so the CPU leaves reset the cycle after RUN is entered.
            cpu_rst_n_q  <= (state_q == S_RUN);
            rvalid_q     <= fch_gnt;
            err_q        <= fch_gnt && fetch_fault;
            if (rvalid_q) begin
                rdata_hold_q <= fetch_rdata;
            end
        end
    end

endmodule
